// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter: count direction and boundary mode.
package mod_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and boundary detection for mod_counter.
// Holds no state; the parent registers o_q_next and the wrap event.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_enable,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_at_bound,
    output logic             o_wrap_event
);

    // MODULUS may equal 2**WIDTH, so the top value is truncated on purpose
    // and the load comparison is done one bit wider to avoid overflow.
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic w_at_max;
    logic w_at_zero;
    logic w_load_ok;

    assign w_at_max   = (i_q == MAX_Q);
    assign w_at_zero  = (i_q == '0);
    assign w_load_ok  = ({1'b0, i_load_value} < MOD_EXT);
    assign o_at_bound = i_enable & ((i_up == DIR_UP) ? w_at_max : w_at_zero);

    always_comb begin
        o_q_next     = i_q;
        o_wrap_event = 1'b0;
        if (i_load) begin
            o_q_next = w_load_ok ? i_load_value : MAX_Q;
        end else if (i_enable) begin
            if (i_up == DIR_UP) begin
                if (w_at_max) begin
                    o_q_next     = (SATURATE == MODE_SAT) ? MAX_Q : '0;
                    o_wrap_event = (SATURATE == MODE_WRAP);
                end else begin
                    o_q_next = i_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    o_q_next     = (SATURATE == MODE_SAT) ? '0 : MAX_Q;
                    o_wrap_event = (SATURATE == MODE_WRAP);
                end else begin
                    o_q_next = i_q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, saturate option, cascade tc and wrap pulse.
// tc is combinational so a downstream stage can use it as its enable.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_bound;
    logic             w_wrap_event;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q          (r_q),
        .i_enable     (enable),
        .i_up         (up),
        .i_load       (load),
        .i_load_value (load_value),
        .o_q_next     (w_q_next),
        .o_at_bound   (w_at_bound),
        .o_wrap_event (w_wrap_event)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_event;
        end
    end

    assign Q    = r_q;
    assign wrap = r_wrap;
    assign tc   = w_at_bound;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap/saturate variants, load clamp,
// direction flip, asynchronous clear and a two-stage cascade.
module tb_mod_counter;

    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic       exp_wrap;
    } vec_t;

    logic clock;
    logic clear;
    logic clear_c;

    logic       a_en, a_up, a_ld;
    logic [3:0] a_lv, a_q;
    logic       a_tc, a_wrap;

    logic       b_en, b_up, b_ld;
    logic [7:0] b_lv, b_q;
    logic       b_tc, b_wrap;

    logic       c_en, c_up, c_ld;
    logic [7:0] c_lv, c_q;
    logic       c_tc, c_wrap;

    logic       cs_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    vec_t vec[23];

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
        .clock(clock), .clear(clear), .enable(a_en), .up(a_up), .load(a_ld),
        .load_value(a_lv), .Q(a_q), .tc(a_tc), .wrap(a_wrap)
    );

    mod_counter #(.WIDTH(8), .MODULUS(200), .SATURATE(1)) u_b (
        .clock(clock), .clear(clear), .enable(b_en), .up(b_up), .load(b_ld),
        .load_value(b_lv), .Q(b_q), .tc(b_tc), .wrap(b_wrap)
    );

    mod_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_c (
        .clock(clock), .clear(clear_c), .enable(c_en), .up(c_up), .load(c_ld),
        .load_value(c_lv), .Q(c_q), .tc(c_tc), .wrap(c_wrap)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_lo (
        .clock(clock), .clear(clear), .enable(cs_en), .up(1'b1), .load(1'b0),
        .load_value(4'd0), .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_hi (
        .clock(clock), .clear(clear), .enable(lo_tc), .up(1'b1), .load(1'b0),
        .load_value(4'd0), .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic en, input logic up,
                                input logic [3:0] lv, input logic tcv,
                                input logic [3:0] q, input logic w);
        vec_t v;
        v.ld = ld; v.en = en; v.up = up; v.lv = lv;
        v.exp_tc = tcv; v.exp_q = q; v.exp_wrap = w;
        return v;
    endfunction

    initial begin
        logic [7:0] b_exp[5];
        logic       b_tc_exp[5];
        int         m;

        // Wrap-up run from reset, then load clamp/priority and down wrap.
        for (int k = 0; k < 9; k++) vec[k] = mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'(k + 1), 1'b0);
        vec[9]  = mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1);
        vec[10] = mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd1, 1'b0);
        vec[11] = mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd2, 1'b0);
        vec[12] = mk(1'b1, 1'b1, 1'b1, 4'd13, 1'b0, 4'd9, 1'b0);
        vec[13] = mk(1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 4'd9, 1'b0);
        vec[14] = mk(1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd9, 1'b0);
        vec[15] = mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0);
        vec[16] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0);
        vec[17] = mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1);
        vec[18] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0);
        vec[19] = mk(1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 4'd5, 1'b0);
        vec[20] = mk(1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 4'd9, 1'b0);
        vec[21] = mk(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0);
        vec[22] = mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1);

        clear = 1'b0; clear_c = 1'b0;
        a_en = 0; a_up = 0; a_ld = 0; a_lv = '0;
        b_en = 0; b_up = 0; b_ld = 0; b_lv = '0;
        c_en = 0; c_up = 0; c_ld = 0; c_lv = '0;
        cs_en = 0;

        #2;
        check("reset_a_q", a_q, 0);
        check("reset_a_wrap", a_wrap, 0);
        check("reset_b_q", b_q, 0);
        check("reset_c_q", c_q, 0);
        check("reset_cascade", {hi_q, lo_q}, 0);

        // Load and enable are ignored while clear is held low.
        a_ld = 1; a_lv = 4'd5; a_en = 1; a_up = 0;
        #1;
        check("reset_tc_down", a_tc, 1);
        tick();
        check("reset_ignores_load", a_q, 0);
        a_ld = 0; a_up = 1;
        #1;
        check("reset_tc_up", a_tc, 0);
        a_en = 0;
        clear = 1'b1; clear_c = 1'b1;

        for (int i = 0; i < 23; i++) begin
            a_ld = vec[i].ld; a_en = vec[i].en; a_up = vec[i].up; a_lv = vec[i].lv;
            #1;
            check($sformatf("vec%0d_tc", i), a_tc, vec[i].exp_tc);
            tick();
            check($sformatf("vec%0d_q", i), a_q, vec[i].exp_q);
            check($sformatf("vec%0d_wrap", i), a_wrap, vec[i].exp_wrap);
        end
        a_ld = 0; a_en = 0;

        // Saturating down count stops at zero without a wrap pulse.
        b_exp    = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        b_tc_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b_ld = 1; b_lv = 8'd3;
        tick();
        check("sat_load", b_q, 3);
        b_ld = 0; b_en = 1; b_up = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("sat_down%0d_tc", i), b_tc, b_tc_exp[i]);
            tick();
            check($sformatf("sat_down%0d_q", i), b_q, b_exp[i]);
            check($sformatf("sat_down%0d_wrap", i), b_wrap, 0);
        end
        b_en = 0; b_ld = 1; b_lv = 8'd250; b_up = 1;
        tick();
        check("sat_load_clamp", b_q, 199);
        b_ld = 0; b_en = 1;
        #1;
        check("sat_up_tc", b_tc, 1);
        tick();
        check("sat_up_hold", b_q, 199);
        check("sat_up_wrap", b_wrap, 0);
        b_en = 0;

        // Direction flip across the 0/255 boundary, wrapping both ways.
        c_en = 1; c_up = 0;
        #1;
        check("flip_tc_down", c_tc, 1);
        tick();
        check("flip_q_255", c_q, 255);
        check("flip_wrap_down", c_wrap, 1);
        c_up = 1;
        #1;
        check("flip_tc_up", c_tc, 1);
        tick();
        check("flip_q_0", c_q, 0);
        check("flip_wrap_up", c_wrap, 1);
        c_en = 0;
        tick();
        check("flip_wrap_single", c_wrap, 0);

        // Asynchronous clear in the middle of a count.
        c_ld = 1; c_lv = 8'h5A;
        tick();
        c_ld = 0;
        check("async_preload", c_q, 8'h5A);
        c_en = 1; c_up = 1;
        #2;
        clear_c = 1'b0;
        #1;
        check("async_q", c_q, 0);
        check("async_wrap", c_wrap, 0);
        tick();
        check("async_held", c_q, 0);
        clear_c = 1'b1;
        tick();
        check("async_resume", c_q, 1);
        c_en = 0;

        // Two 4-bit stages chained through tc behave as one 8-bit counter.
        cs_en = 1;
        m = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            m = (m + 1) % 256;
            exp_q.push_back(8'(m));
            check("cascade", {hi_q, lo_q}, exp_q.pop_front());
        end
        check("cascade_final", {hi_q, lo_q}, 8'h2C);
        cs_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: count register width in bits.
REQ-002 Parameter MODULUS, default 256: number of count states; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the count bounds, 1 = hold at the count bounds.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port enable, input, 1 bit: count enable.
REQ-007 Port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 Port load, input, 1 bit: synchronous load strobe.
REQ-009 Port load_value, input, WIDTH bits: value to load.
REQ-010 Port Q, output, WIDTH bits: registered count value.
REQ-011 Port tc, output, 1 bit: combinational terminal count, used for cascading.
REQ-012 Port wrap, output, 1 bit: registered one-cycle pulse indicating that a wrap occurred.

Function
REQ-013 Per-edge priority SHALL be load, then enable count, then hold.
REQ-014 Load SHALL set Q to load_value if load_value < MODULUS, otherwise to MODULUS-1 (clamped); it ignores enable and up.
REQ-015 With enable=1 and up=1, Q SHALL increment by 1 per edge; when Q==MODULUS-1 the next Q SHALL be 0 (SATURATE=0) or MODULUS-1 (SATURATE=1).
REQ-016 With enable=1 and up=0, Q SHALL decrement by 1 per edge; when Q==0 the next Q SHALL be MODULUS-1 (SATURATE=0) or 0 (SATURATE=1).
REQ-017 With enable=0 and load=0, Q SHALL hold.
REQ-018 tc SHALL equal enable & ((up & Q==MODULUS-1) | (~up & Q==0)), with no register stage, regardless of SATURATE.
REQ-019 wrap SHALL be 1 for exactly the one cycle after an edge on which a boundary wrap occurred, and 0 otherwise.
REQ-020 wrap SHALL never assert when SATURATE=1, nor on any load edge.
REQ-021 A change of up SHALL take effect on the next edge, with no dead cycle.
REQ-022 The count SHALL be computed modulo MODULUS at WIDTH bits, with no intermediate overflow; Q SHALL never hold a value >= MODULUS after reset or load.
REQ-023 Cascading SHALL work by driving a downstream counter's enable from an upstream counter's tc; a 2-stage 4-bit cascade SHALL be equivalent to one 8-bit counter.

Reset
REQ-024 clear=0 SHALL immediately force Q=0 and wrap=0, independent of clock.
REQ-025 While clear=0, load and enable SHALL be ignored; tc SHALL follow REQ-018 with Q=0.
REQ-026 Counting SHALL resume on the first rising clock edge after clear deasserts; a reset mid-count discards the count.

Structure
REQ-027 The shared package SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0, and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-028 A single sub-module, mod_counter_next, SHALL provide the combinational next-state and boundary detection; mod_counter SHALL hold only the registers and the tc/wrap logic.
REQ-029 Display decoding SHALL stay outside this block; the existing hex decoder is instantiated at top level.
REQ-030 Parameter legality (REQ-002) SHALL be checked at elaboration, and an illegal value SHALL be a fatal error.

Verification
REQ-031 Wrap up: WIDTH=4, MODULUS=10, SATURATE=0, enable=1, up=1, 12 edges from reset -> Q runs 1..9, 0, 1, 2; tc high while Q=9; wrap high exactly one cycle after 9->0.
REQ-032 Saturate down: WIDTH=8, MODULUS=200, SATURATE=1, load 3, then up=0 for 5 edges -> Q = 2, 1, 0, 0, 0; wrap never 1; tc=1 while Q=0.
REQ-033 Load clamp and priority: MODULUS=10, load_value=13, load=1, enable=1 -> Q=9 and wrap=0; then load_value=9 with load=1 while Q=9 and up=1 -> Q stays 9, no wrap.
REQ-034 Direction flip: WIDTH=8, MODULUS=256, at Q=0 with up=0 -> next Q=255 with wrap; flip up=1 on the next edge -> Q=0 with wrap again.
REQ-035 Async reset mid-count: assert clear=0 between edges at Q=0x5A -> Q=0 and wrap=0 before the next edge; the first edge after release gives Q=1.
REQ-036 Cascade: two 4-bit MODULUS=16 instances chained via tc, 300 enabled edges -> combined value equals 300 mod 256 = 44 (0x2C).
